// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and defaults for the PWM setpoint path
`timescale 1ns/1ps

package pwm_pkg;

  // Setpoint dither controller states.
  //   IDLE : no target has been written since reset; ticks are ignored
  //   RAMP : working value still slewing toward the target
  //   LOCK : working value has reached the target
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    LOCK = 2'd2
  } ditherState_t;

  // Default compare width and number of sub-LSB fraction bits.
  localparam int DEFAULT_WIDTH    = 18;
  localparam int DEFAULT_FRACBITS = 4;

endpackage : pwm_pkg

// File: rtl/pwm_dither.sv
// rtl/pwm_dither.sv - first-order error-feedback quantizer (combinational)
`timescale 1ns/1ps

module pwm_dither
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int FRACBITS = DEFAULT_FRACBITS
) (
  input  logic [WIDTH+FRACBITS-1:0] cur,
  input  logic [FRACBITS-1:0]       err,
  output logic [WIDTH-1:0]          q,
  output logic                      saturated,
  output logic [FRACBITS-1:0]       errNext
);

  logic [FRACBITS:0] sum;
  logic [WIDTH:0]    q_full;

  // Add the carried-over fraction error to this period's fraction; the carry
  // out bumps the integer part by one LSB and the remainder is fed forward.
  always_comb begin
    sum       = {1'b0, cur[FRACBITS-1:0]} + {1'b0, err};
    errNext   = sum[FRACBITS-1:0];
    q_full    = {1'b0, cur[WIDTH+FRACBITS-1:FRACBITS]} + {{WIDTH{1'b0}}, sum[FRACBITS]};
    q         = q_full[WIDTH-1:0];
    saturated = q_full[WIDTH];
  end

endmodule : pwm_dither

// File: rtl/pwm_setpoint_dither.sv
// rtl/pwm_setpoint_dither.sv - slewed, dithered duty setpoint feeder for the PWM cmpA input
`timescale 1ns/1ps

module pwm_setpoint_dither
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int FRACBITS = DEFAULT_FRACBITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH+FRACBITS-1:0] setIn,
  input  logic                      setValid,
  output logic                      setReady,
  input  logic [WIDTH-1:0]          slewLimit,
  input  logic                      prdTick,
  output logic [WIDTH-1:0]          cmpA,
  output logic                      cmpUpd,
  output logic                      busy
);

  localparam int TW = WIDTH + FRACBITS;

  ditherState_t          state_q;
  ditherState_t          state_d;
  logic [TW-1:0]         target_q;
  logic [TW-1:0]         cur_q;
  logic [FRACBITS-1:0]   err_q;
  logic [WIDTH-1:0]      cmp_q;
  logic                  cmp_upd_q;
  logic                  rdy_q;

  logic                  wr_fire;
  logic                  tick_fire;
  logic                  dir_up;
  logic [TW-1:0]         mag;
  logic [TW-1:0]         step;
  logic                  jump;
  logic [TW-1:0]         cur_step;

  logic [WIDTH-1:0]      q_raw;
  logic                  q_sat;
  logic [FRACBITS-1:0]   err_next;

  // The target register is never written in a tick cycle, so a write and a
  // slew step can never collide; rdy_q only masks the reset cycle itself.
  assign setReady  = rdy_q & ~prdTick;
  assign wr_fire   = setValid & setReady;
  assign tick_fire = prdTick & (state_q != IDLE);

  assign cmpA   = cmp_q;
  assign cmpUpd = cmp_upd_q;
  assign busy   = (state_q == RAMP);

  // Slew step: the magnitude of target-cur is compared against the limit
  // scaled to fraction units; within reach (or no limit) the step lands
  // exactly on the target, otherwise cur moves one full limit toward it.
  always_comb begin
    dir_up   = (target_q >= cur_q);
    mag      = dir_up ? (target_q - cur_q) : (cur_q - target_q);
    step     = {slewLimit, {FRACBITS{1'b0}}};
    jump     = (slewLimit == '0) || (mag <= step);
    cur_step = target_q;
    if (!jump) begin
      cur_step = dir_up ? (cur_q + step) : (cur_q - step);
    end
  end

  // Quantize the post-step working value with the running fraction error.
  pwm_dither #(
    .WIDTH    (WIDTH),
    .FRACBITS (FRACBITS)
  ) u_dither (
    .cur       (cur_step),
    .err       (err_q),
    .q         (q_raw),
    .saturated (q_sat),
    .errNext   (err_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: writes choose RAMP/LOCK against the current working value;
  // ticks settle into LOCK once the step lands on the target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          state_d = (setIn != cur_q) ? RAMP : LOCK;
        end
      end
      RAMP, LOCK: begin
        if (wr_fire) begin
          state_d = (setIn != cur_q) ? RAMP : LOCK;
        end else if (prdTick) begin
          state_d = (cur_step == target_q) ? LOCK : RAMP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake, target, working value, error feedback and compare output.
  // The error is deliberately kept across target changes so the noise
  // shaping stays continuous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b0;
      target_q  <= '0;
      cur_q     <= '0;
      err_q     <= '0;
      cmp_q     <= '0;
      cmp_upd_q <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      cmp_upd_q <= 1'b0;
      if (wr_fire) begin
        target_q <= setIn;
      end
      if (tick_fire) begin
        cur_q     <= cur_step;
        err_q     <= err_next;
        cmp_q     <= q_sat ? {WIDTH{1'b1}} : q_raw;
        cmp_upd_q <= 1'b1;
      end
    end
  end

endmodule : pwm_setpoint_dither

// File: tb/tb_pwm_setpoint_dither.sv
// tb/tb_pwm_setpoint_dither.sv - directed self-checking bench for pwm_setpoint_dither
`timescale 1ns/1ps

module tb_pwm_setpoint_dither;

  localparam int W = 18;
  localparam int F = 4;

  logic           clk;
  logic           rst;
  logic [W+F-1:0] setIn;
  logic           setValid;
  logic           setReady;
  logic [W-1:0]   slewLimit;
  logic           prdTick;
  logic [W-1:0]   cmpA;
  logic           cmpUpd;
  logic           busy;

  int errors;
  int checks;

  pwm_setpoint_dither #(
    .WIDTH    (W),
    .FRACBITS (F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .setIn     (setIn),
    .setValid  (setValid),
    .setReady  (setReady),
    .slewLimit (slewLimit),
    .prdTick   (prdTick),
    .cmpA      (cmpA),
    .cmpUpd    (cmpUpd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clocks, landing 1 ns after the last rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle period tick; returns 1 ns after the edge that consumed it.
  task automatic tick_once();
    prdTick = 1'b1;
    @(posedge clk);
    #1;
    prdTick = 1'b0;
  endtask

  // Present a setpoint and hold it until accepted (bounded wait).
  task automatic write_set(input logic [W+F-1:0] v);
    int waited;
    waited   = 0;
    setIn    = v;
    setValid = 1'b1;
    while (!setReady && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (setReady !== 1'b1) begin
      $display("FAIL write_handshake: setReady=%b required 1 within 20 cycles", setReady);
      errors++;
    end
    @(posedge clk);
    #1;
    setValid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++; if (cmpA !== '0) begin $display("FAIL reset_cmpA: got %0h required 0", cmpA); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); errors++; end
    checks++; if (setReady !== 1'b0) begin $display("FAIL reset_setReady: got %b required 0", setReady); errors++; end
    checks++; if (cmpUpd !== 1'b0) begin $display("FAIL reset_cmpUpd: got %b required 0", cmpUpd); errors++; end
    rst = 1'b0;
    #1;
    checks++; if (setReady !== 1'b0) begin $display("FAIL release_setReady: got %b required 0", setReady); errors++; end
    idle(1);
    checks++; if (setReady !== 1'b1) begin $display("FAIL first_clk_setReady: got %b required 1", setReady); errors++; end
    tick_once();
    checks++; if (cmpUpd !== 1'b0) begin $display("FAIL idle_tick_cmpUpd: got %b required 0", cmpUpd); errors++; end
    checks++; if (cmpA !== '0) begin $display("FAIL idle_tick_cmpA: got %0h required 0", cmpA); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL idle_tick_busy: got %b required 0", busy); errors++; end
  endtask

  task automatic test_dither_half();
    logic [W-1:0] exp_q [4];
    exp_q = '{18'h10, 18'h11, 18'h10, 18'h11};
    slewLimit = '0;
    write_set(22'h108);
    checks++; if (busy !== 1'b1) begin $display("FAIL half_busy_after_write: got %b required 1", busy); errors++; end
    for (int i = 0; i < 4; i++) begin
      tick_once();
      checks++; if (cmpA !== exp_q[i]) begin $display("FAIL half_cmpA[%0d]: got %0h required %0h", i, cmpA, exp_q[i]); errors++; end
      checks++; if (cmpUpd !== 1'b1) begin $display("FAIL half_cmpUpd[%0d]: got %b required 1", i, cmpUpd); errors++; end
      checks++; if (busy !== 1'b0) begin $display("FAIL half_busy[%0d]: got %b required 0", i, busy); errors++; end
      idle(1);
      checks++; if (cmpUpd !== 1'b0) begin $display("FAIL half_cmpUpd_pulse[%0d]: got %b required 0", i, cmpUpd); errors++; end
      idle(18);
    end
  endtask

  task automatic test_slew();
    logic [W-1:0] exp_q [5];
    logic         exp_b [5];
    exp_q = '{18'd30, 18'd60, 18'd90, 18'd100, 18'd100};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    slewLimit = 18'd30;
    write_set({18'd100, 4'h0});
    for (int i = 0; i < 5; i++) begin
      tick_once();
      checks++; if (cmpA !== exp_q[i]) begin $display("FAIL slew_cmpA[%0d]: got %0d required %0d", i, cmpA, exp_q[i]); errors++; end
      checks++; if (busy !== exp_b[i]) begin $display("FAIL slew_busy[%0d]: got %b required %b", i, busy, exp_b[i]); errors++; end
      idle(19);
    end
  endtask

  task automatic test_frac3();
    int hi;
    hi = 0;
    slewLimit = '0;
    write_set({18'd50, 4'h3});
    for (int i = 0; i < 16; i++) begin
      tick_once();
      if (cmpA == 18'd51) hi++;
      checks++; if (cmpA !== 18'd50 && cmpA !== 18'd51) begin $display("FAIL frac3_range[%0d]: got %0d required 50 or 51", i, cmpA); errors++; end
      idle(4);
    end
    checks++; if (hi !== 3) begin $display("FAIL frac3_count: got %0d required 3", hi); errors++; end
  endtask

  task automatic test_saturate();
    slewLimit = '0;
    write_set(22'h3FFFFF);
    for (int i = 0; i < 4; i++) begin
      tick_once();
      checks++; if (cmpA !== 18'h3FFFF) begin $display("FAIL sat_cmpA[%0d]: got %0h required 3ffff", i, cmpA); errors++; end
      idle(3);
    end
  endtask

  task automatic test_tick_collision();
    setIn    = {18'd7, 4'h0};
    setValid = 1'b1;
    prdTick  = 1'b1;
    #1;
    checks++; if (setReady !== 1'b0) begin $display("FAIL coll_setReady_tick: got %b required 0", setReady); errors++; end
    @(posedge clk);
    #1;
    prdTick = 1'b0;
    checks++; if (cmpA !== 18'h3FFFF) begin $display("FAIL coll_old_target: got %0h required 3ffff", cmpA); errors++; end
    checks++; if (cmpUpd !== 1'b1) begin $display("FAIL coll_cmpUpd: got %b required 1", cmpUpd); errors++; end
    #1;
    checks++; if (setReady !== 1'b1) begin $display("FAIL coll_setReady_after: got %b required 1", setReady); errors++; end
    @(posedge clk);
    #1;
    setValid = 1'b0;
    checks++; if (busy !== 1'b1) begin $display("FAIL coll_busy: got %b required 1", busy); errors++; end
    idle(3);
    tick_once();
    checks++; if (cmpA !== 18'd7) begin $display("FAIL coll_new_target: got %0d required 7", cmpA); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL coll_busy_done: got %b required 0", busy); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] expv;
    slewLimit = 18'd1;
    write_set({18'd10, 4'h0});
    prdTick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expv = W'(8 + i);
      checks++; if (cmpA !== expv) begin $display("FAIL b2b_cmpA[%0d]: got %0d required %0d", i, cmpA, expv); errors++; end
      checks++; if (cmpUpd !== 1'b1) begin $display("FAIL b2b_cmpUpd[%0d]: got %b required 1", i, cmpUpd); errors++; end
      checks++; if (setReady !== 1'b0) begin $display("FAIL b2b_setReady[%0d]: got %b required 0", i, setReady); errors++; end
    end
    prdTick = 1'b0;
    checks++; if (busy !== 1'b0) begin $display("FAIL b2b_busy: got %b required 0", busy); errors++; end
    idle(1);
    checks++; if (cmpUpd !== 1'b0) begin $display("FAIL b2b_cmpUpd_end: got %b required 0", cmpUpd); errors++; end
  endtask

  task automatic test_async_reset();
    slewLimit = 18'd1;
    write_set({18'd100, 4'h0});
    tick_once();
    checks++; if (cmpA !== 18'd11) begin $display("FAIL arst_pre_cmpA: got %0d required 11", cmpA); errors++; end
    checks++; if (busy !== 1'b1) begin $display("FAIL arst_pre_busy: got %b required 1", busy); errors++; end
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (cmpA !== '0) begin $display("FAIL arst_cmpA: got %0d required 0", cmpA); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL arst_busy: got %b required 0", busy); errors++; end
    checks++; if (setReady !== 1'b0) begin $display("FAIL arst_setReady: got %b required 0", setReady); errors++; end
    #2;
    rst = 1'b0;
    idle(1);
    tick_once();
    checks++; if (cmpUpd !== 1'b0) begin $display("FAIL arst_tick_cmpUpd: got %b required 0", cmpUpd); errors++; end
    checks++; if (cmpA !== '0) begin $display("FAIL arst_tick_cmpA: got %0d required 0", cmpA); errors++; end
    slewLimit = '0;
    write_set({18'd5, 4'h0});
    tick_once();
    checks++; if (cmpA !== 18'd5) begin $display("FAIL arst_rewrite_cmpA: got %0d required 5", cmpA); errors++; end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    setIn     = '0;
    setValid  = 1'b0;
    slewLimit = '0;
    prdTick   = 1'b0;
    test_reset();
    test_dither_half();
    test_slew();
    test_frac3();
    test_saturate();
    test_tick_collision();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_setpoint_dither
